// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/load-store ports, the memory strobes and the
// shared data bus. The arbiter connects through the slave modport.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid;

  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_valid;

  logic        mem_d_read;
  logic        mem_d_write;
  logic        mem_d_push;
  logic        mem_i_read;
  logic        mem_i_push;
  logic [15:0] mem_d_addr;
  logic [15:0] mem_i_addr;

  logic [15:0] bus_out;
  logic        bus_oe;
  logic [15:0] bus_in;
  logic        oob_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_in,
    output if_rdata, if_valid, dm_rdata, dm_valid,
    output mem_d_read, mem_d_write, mem_d_push, mem_i_read, mem_i_push,
    output mem_d_addr, mem_i_addr, bus_out, bus_oe, oob_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, bus_in,
    input  if_rdata, if_valid, dm_rdata, dm_valid,
    input  mem_d_read, mem_d_write, mem_d_push, mem_i_read, mem_i_push,
    input  mem_d_addr, mem_i_addr, bus_out, bus_oe, oob_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port 16-bit memory between instruction
// fetch and load/store, sequencing read/push/write strobes and range-checking.
module mem_arbiter #(
  parameter int unsigned MEM_SIZE = 512
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave arb
);
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_PUSH, WR, OOB} state_e;
  typedef enum logic {PORT_FETCH, PORT_DATA} port_e;

  state_e      state;
  port_e       cur_port;
  port_e       last_gnt;
  logic        we_q;

  logic [15:0] if_rdata_q;
  logic        if_valid_q;
  logic [15:0] dm_rdata_q;
  logic        dm_valid_q;
  logic        d_read_q, d_write_q, d_push_q, i_read_q, i_push_q;
  logic [15:0] d_addr_q, i_addr_q;
  logic [15:0] bus_out_q;
  logic        bus_oe_q;
  logic        oob_q;

  logic        if_elig, dm_elig, any_elig, pick_fetch;
  logic        gnt_store, gnt_oob;
  logic [15:0] gnt_addr;

  // A port whose valid is high this cycle has just completed; its req is stale.
  assign if_elig    = arb.if_req && !if_valid_q;
  assign dm_elig    = arb.dm_req && !dm_valid_q;
  assign any_elig   = if_elig || dm_elig;
  assign pick_fetch = if_elig && (!dm_elig || last_gnt == PORT_DATA);
  assign gnt_addr   = pick_fetch ? arb.if_addr : arb.dm_addr;
  assign gnt_store  = !pick_fetch && arb.dm_we;
  assign gnt_oob    = 32'(gnt_addr) >= MEM_SIZE;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_port   <= PORT_FETCH;
      last_gnt   <= PORT_DATA;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_rdata_q <= '0;
      dm_valid_q <= 1'b0;
      d_read_q   <= 1'b0;
      d_write_q  <= 1'b0;
      d_push_q   <= 1'b0;
      i_read_q   <= 1'b0;
      i_push_q   <= 1'b0;
      d_addr_q   <= '0;
      i_addr_q   <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      // Strobes, addresses and valids are single-cycle unless re-set below.
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      d_read_q   <= 1'b0;
      d_write_q  <= 1'b0;
      d_push_q   <= 1'b0;
      i_read_q   <= 1'b0;
      i_push_q   <= 1'b0;
      d_addr_q   <= '0;
      i_addr_q   <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (any_elig) begin
            cur_port <= pick_fetch ? PORT_FETCH : PORT_DATA;
            last_gnt <= pick_fetch ? PORT_FETCH : PORT_DATA;
            we_q     <= gnt_store;
            if (gnt_oob) begin
              state <= OOB;
            end else if (gnt_store) begin
              state     <= WR;
              d_write_q <= 1'b1;
              bus_oe_q  <= 1'b1;
              bus_out_q <= arb.dm_wdata;
              d_addr_q  <= gnt_addr;
            end else begin
              state <= RD_ISSUE;
              if (pick_fetch) begin
                i_read_q <= 1'b1;
                i_addr_q <= gnt_addr;
              end else begin
                d_read_q <= 1'b1;
                d_addr_q <= gnt_addr;
              end
            end
          end
        end

        RD_ISSUE: begin
          state <= RD_PUSH;
          if (cur_port == PORT_FETCH) i_push_q <= 1'b1;
          else                        d_push_q <= 1'b1;
        end

        RD_PUSH: begin
          state <= IDLE;
          if (cur_port == PORT_FETCH) begin
            if_rdata_q <= arb.bus_in;
            if_valid_q <= 1'b1;
          end else begin
            dm_rdata_q <= arb.bus_in;
            dm_valid_q <= 1'b1;
          end
        end

        WR: begin
          state      <= IDLE;
          dm_valid_q <= 1'b1;
        end

        OOB: begin
          // Out-of-range loads return zero; out-of-range stores are dropped.
          state <= IDLE;
          oob_q <= 1'b1;
          if (cur_port == PORT_FETCH) begin
            if_rdata_q <= '0;
            if_valid_q <= 1'b1;
          end else begin
            if (!we_q) dm_rdata_q <= '0;
            dm_valid_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign arb.if_rdata    = if_rdata_q;
  assign arb.if_valid    = if_valid_q;
  assign arb.dm_rdata    = dm_rdata_q;
  assign arb.dm_valid    = dm_valid_q;
  assign arb.mem_d_read  = d_read_q;
  assign arb.mem_d_write = d_write_q;
  assign arb.mem_d_push  = d_push_q;
  assign arb.mem_i_read  = i_read_q;
  assign arb.mem_i_push  = i_push_q;
  assign arb.mem_d_addr  = d_addr_q;
  assign arb.mem_i_addr  = i_addr_q;
  assign arb.bus_out     = bus_out_q;
  assign arb.bus_oe      = bus_oe_q;
  assign arb.oob_err     = oob_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory on the strobes,
// directed protocol checks and randomized dual-port traffic against a word model.
module tb_mem_arbiter;
  localparam int MEM_SIZE = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if arb();

  mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .arb  (arb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory block driven by the arbiter's strobes; ref_mem is the expected content.
  logic [15:0] mem     [MEM_SIZE];
  logic [15:0] ref_mem [MEM_SIZE];
  logic [15:0] rd_addr = 16'h0;

  always @(posedge clk) begin
    if (arb.mem_d_read)      rd_addr <= arb.mem_d_addr;
    else if (arb.mem_i_read) rd_addr <= arb.mem_i_addr;
    if (arb.mem_d_write && arb.bus_oe) mem[arb.mem_d_addr[8:0]] <= arb.bus_out;
  end

  assign arb.bus_in = (arb.mem_d_push || arb.mem_i_push) ? mem[rd_addr[8:0]] : 16'h0000;

  function automatic logic [4:0] strobes();
    return {arb.mem_d_read, arb.mem_d_write, arb.mem_d_push, arb.mem_i_read, arb.mem_i_push};
  endfunction

  function automatic logic [88:0] out_vec();
    return {arb.if_rdata, arb.if_valid, arb.dm_rdata, arb.dm_valid, strobes(),
            arb.mem_d_addr, arb.mem_i_addr, arb.bus_out, arb.bus_oe, arb.oob_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arb.if_req   = 1'b0;
    arb.if_addr  = 16'h0;
    arb.dm_req   = 1'b0;
    arb.dm_we    = 1'b0;
    arb.dm_addr  = 16'h0;
    arb.dm_wdata = 16'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic dm_xfer(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         output logic [15:0] rdata, output int lat);
    arb.dm_req = 1'b1; arb.dm_we = we; arb.dm_addr = addr; arb.dm_wdata = wdata;
    lat = 0;
    do begin tick(); lat++; end while (!arb.dm_valid && lat < 40);
    if (!arb.dm_valid) lat = -1;
    rdata = arb.dm_rdata;
    arb.dm_req = 1'b0;
  endtask

  task automatic if_xfer(input logic [15:0] addr, output logic [15:0] rdata, output int lat);
    arb.if_req = 1'b1; arb.if_addr = addr;
    lat = 0;
    do begin tick(); lat++; end while (!arb.if_valid && lat < 40);
    if (!arb.if_valid) lat = -1;
    rdata = arb.if_rdata;
    arb.if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arb.if_req = 1'b1; arb.if_addr = 16'h3;
    arb.dm_req = 1'b1; arb.dm_addr = 16'h4; arb.dm_we = 1'b0; arb.dm_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_vec() !== '0) begin
      n_bad++; $display("FAIL reset_hold: outputs=%h expected all zero", out_vec());
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (out_vec() !== '0) begin
      n_bad++; $display("FAIL reset_release_idle: outputs=%h expected all zero", out_vec());
    end
  endtask

  task automatic test_single_load();
    logic [15:0] rd;
    int lat;
    dm_xfer(1'b1, 16'd5, 16'h1234, rd, lat);
    ref_mem[5] = 16'h1234;
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL store5_latency: got %0d expected 2", lat); end
    tick();
    arb.dm_req = 1'b1; arb.dm_we = 1'b0; arb.dm_addr = 16'd5;
    tick();
    n_cmp++;
    if (strobes() !== 5'b10000 || arb.mem_d_addr !== 16'd5) begin
      n_bad++; $display("FAIL load_cycle1: strobes=%b addr=%h expected 10000/0005", strobes(), arb.mem_d_addr);
    end
    tick();
    n_cmp++;
    if (strobes() !== 5'b00100 || arb.dm_valid !== 1'b0) begin
      n_bad++; $display("FAIL load_cycle2: strobes=%b valid=%b expected 00100/0", strobes(), arb.dm_valid);
    end
    tick();
    n_cmp++;
    if (arb.dm_valid !== 1'b1 || arb.dm_rdata !== ref_mem[5] || strobes() !== 5'b0) begin
      n_bad++; $display("FAIL load_cycle3: valid=%b rdata=%h expected 1/%h", arb.dm_valid, arb.dm_rdata, ref_mem[5]);
    end
    arb.dm_req = 1'b0;
    tick();
    n_cmp++;
    if (arb.dm_valid !== 1'b0 || arb.dm_rdata !== ref_mem[5]) begin
      n_bad++; $display("FAIL load_hold: valid=%b rdata=%h expected 0/%h", arb.dm_valid, arb.dm_rdata, ref_mem[5]);
    end
  endtask

  task automatic test_store();
    logic [15:0] rd;
    int lat;
    arb.dm_req = 1'b1; arb.dm_we = 1'b1; arb.dm_addr = 16'h0010; arb.dm_wdata = 16'hBEEF;
    tick();
    n_cmp++;
    if (strobes() !== 5'b01000 || arb.bus_oe !== 1'b1 || arb.bus_out !== 16'hBEEF || arb.mem_d_addr !== 16'h0010) begin
      n_bad++; $display("FAIL store_cycle1: strobes=%b oe=%b bus=%h addr=%h expected 01000/1/beef/0010",
                        strobes(), arb.bus_oe, arb.bus_out, arb.mem_d_addr);
    end
    tick();
    ref_mem[16] = 16'hBEEF;
    n_cmp++;
    if (arb.dm_valid !== 1'b1 || strobes() !== 5'b0 || arb.bus_oe !== 1'b0) begin
      n_bad++; $display("FAIL store_cycle2: valid=%b strobes=%b oe=%b expected 1/00000/0", arb.dm_valid, strobes(), arb.bus_oe);
    end
    arb.dm_req = 1'b0;
    tick();
    if_xfer(16'h0010, rd, lat);
    n_cmp++;
    if (lat !== 3 || rd !== ref_mem[16]) begin
      n_bad++; $display("FAIL fetch_after_store: lat=%0d data=%h expected 3/%h", lat, rd, ref_mem[16]);
    end
    tick();
  endtask

  task automatic test_oob();
    logic [15:0] rd;
    int lat, diffs;
    arb.if_req = 1'b1; arb.if_addr = 16'd512;
    tick();
    n_cmp++;
    if (strobes() !== 5'b0 || arb.bus_oe !== 1'b0 || arb.if_valid !== 1'b0) begin
      n_bad++; $display("FAIL oob_cycle1: strobes=%b oe=%b valid=%b expected 00000/0/0", strobes(), arb.bus_oe, arb.if_valid);
    end
    tick();
    n_cmp++;
    if (arb.if_valid !== 1'b1 || arb.if_rdata !== 16'h0 || arb.oob_err !== 1'b1) begin
      n_bad++; $display("FAIL oob_fetch: valid=%b rdata=%h err=%b expected 1/0000/1", arb.if_valid, arb.if_rdata, arb.oob_err);
    end
    arb.if_req = 1'b0;
    tick();
    dm_xfer(1'b1, 16'hFFFF, 16'h5A5A, rd, lat);
    n_cmp++;
    if (lat !== 2 || arb.oob_err !== 1'b1) begin
      n_bad++; $display("FAIL oob_store: lat=%0d err=%b expected 2/1", lat, arb.oob_err);
    end
    tick();
    diffs = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs !== 0) begin n_bad++; $display("FAIL oob_store_mem: %0d words changed expected 0", diffs); end
    dm_xfer(1'b0, 16'd5, 16'h0, rd, lat);
    n_cmp++;
    if (rd !== ref_mem[5] || lat !== 3 || arb.oob_err !== 1'b1) begin
      n_bad++; $display("FAIL oob_sticky: data=%h lat=%0d err=%b expected %h/3/1", rd, lat, arb.oob_err, ref_mem[5]);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    int n;
    arb.dm_req = 1'b1; arb.dm_we = 1'b0; arb.dm_addr = 16'd5;
    tick();
    tick();
    n_cmp++;
    if (strobes() !== 5'b00100) begin
      n_bad++; $display("FAIL midread_push: strobes=%b expected 00100", strobes());
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_vec() !== '0) begin
      n_bad++; $display("FAIL midread_async_reset: outputs=%h expected all zero", out_vec());
    end
    tick();
    n_cmp++;
    if (arb.dm_valid !== 1'b0) begin n_bad++; $display("FAIL midread_no_valid: valid=%b expected 0", arb.dm_valid); end
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arb.dm_valid && n < 40);
    n_cmp++;
    if (n !== 3 || arb.dm_valid !== 1'b1 || arb.dm_rdata !== ref_mem[5]) begin
      n_bad++; $display("FAIL midread_reissue: lat=%0d rdata=%h expected 3/%h", n, arb.dm_rdata, ref_mem[5]);
    end
    arb.dm_req = 1'b0;
    tick();
  endtask

  task automatic test_held_req();
    logic [15:0] a;
    logic [15:0] read_mask, valid_mask, exp_read, exp_valid;
    int data_bad;
    a = 16'($urandom_range(0, MEM_SIZE - 1));
    read_mask = '0; valid_mask = '0; exp_read = '0; exp_valid = '0; data_bad = 0;
    // Each fetch is 3 cycles plus the valid cycle in which it may not be re-granted.
    for (int c = 1; c <= 16; c++) begin
      if ((c - 1) % 4 == 0) exp_read[c-1]  = 1'b1;
      if (c % 4 == 3)       exp_valid[c-1] = 1'b1;
    end
    arb.if_req = 1'b1; arb.if_addr = a;
    for (int c = 1; c <= 16; c++) begin
      tick();
      read_mask[c-1]  = arb.mem_i_read;
      valid_mask[c-1] = arb.if_valid;
      if (arb.if_valid && arb.if_rdata !== ref_mem[a]) data_bad++;
    end
    arb.if_req = 1'b0;
    n_cmp++;
    if (read_mask !== exp_read) begin
      n_bad++; $display("FAIL held_req_grants: read cycles=%b expected %b", read_mask, exp_read);
    end
    n_cmp++;
    if (valid_mask !== exp_valid) begin
      n_bad++; $display("FAIL held_req_valids: valid cycles=%b expected %b", valid_mask, exp_valid);
    end
    n_cmp++;
    if (data_bad !== 0) begin n_bad++; $display("FAIL held_req_data: %0d bad words expected 0", data_bad); end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int order[$];
    int order_bad;
    apply_reset();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [15:0] a;
          int n;
          a = 16'($urandom_range(0, 7));
          arb.if_req = 1'b1; arb.if_addr = a;
          n = 0;
          do begin tick(); n++; end while (!arb.if_valid && n < 40);
          n_cmp++;
          if (!arb.if_valid || arb.if_rdata !== ref_mem[a]) begin
            n_bad++; $display("FAIL rr_fetch[%0d]: valid=%b data=%h expected 1/%h", k, arb.if_valid, arb.if_rdata, ref_mem[a]);
          end
          order.push_back(0);
        end
        arb.if_req = 1'b0;
      end
      begin
        for (int k = 0; k < 8; k++) begin
          logic [15:0] a, wd;
          logic we;
          int n;
          a  = 16'($urandom_range(0, 7));
          wd = 16'($urandom);
          we = 1'($urandom_range(0, 1));
          arb.dm_req = 1'b1; arb.dm_we = we; arb.dm_addr = a; arb.dm_wdata = wd;
          n = 0;
          do begin tick(); n++; end while (!arb.dm_valid && n < 40);
          n_cmp++;
          if (!arb.dm_valid || (!we && arb.dm_rdata !== ref_mem[a])) begin
            n_bad++; $display("FAIL rr_data[%0d]: we=%b valid=%b data=%h expected 1/%h", k, we, arb.dm_valid, arb.dm_rdata, ref_mem[a]);
          end
          if (we) ref_mem[a] = wd;
          order.push_back(1);
        end
        arb.dm_req = 1'b0;
      end
    join
    order_bad = (order.size() == 16) ? 0 : 1;
    foreach (order[i]) if (order[i] != (i % 2)) order_bad++;
    n_cmp++;
    if (order_bad !== 0) begin
      n_bad++; $display("FAIL rr_order: %0d deviations from fetch-first alternation (%0d completions)", order_bad, order.size());
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    idle_inputs();
    test_reset();
    test_single_load();
    test_store();
    test_oob();
    test_reset_mid_read();
    test_held_req();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
